// File: rtl/axi_rd_sched_pkg.sv
// Shared types and helpers for the AXI read-address scheduler.
// Optional feature macro used by this block: AXI_RD_SCHED_PRIO0_EN.
package axi_rd_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int NUM_REQ_DEF = 4;
    localparam int IDX_W       = clog2(NUM_REQ_DEF);

endpackage

// File: rtl/axi_rd_sched_arb.sv
// Combinational round-robin arbiter; search starts at last_grant+1.
// AXI_RD_SCHED_PRIO0_EN: requester 0 always wins, others rotate.
module rr_arbiter
    import axi_rd_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld
);

`ifdef AXI_RD_SCHED_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    int            j;
    logic [IW-1:0] jj;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        j         = 0;
        jj        = '0;
        if (PRIO0 && req[0]) begin
            grant[0]  = 1'b1;
            grant_vld = 1'b1;
        end
        for (int k = 1; k <= N; k++) begin
            j  = (int'(last_grant) + k) % N;
            jj = IW'(j);
            if (!grant_vld && req[jj] && !(PRIO0 && jj == '0)) begin
                grant[jj] = 1'b1;
                grant_idx = jj;
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_rd_sched.sv
// AXI read-address scheduler: arbitrates requesters onto one AR channel.
// Define AXI_RD_SCHED_PRIO0_EN to give requester 0 strict priority.
module axi_rd_sched
    import axi_rd_sched_pkg::*;
#(
    parameter  int NUM_REQ         = 4,
    parameter  int ADDR_WIDTH      = 28,
    parameter  int LOW_W           = 2,
    parameter  int MAX_OUTSTANDING = 8,
    localparam int ID_W            = clog2(NUM_REQ),
    localparam int OUT_W           = clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]          req_len,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [7:0]                    m_arlen,
    output logic [ID_W-1:0]               m_arid,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic                          m_rvalid,
    input  logic                          m_rready,
    input  logic                          m_rlast,
    output logic                          tag_wr_en,
    output logic [ID_W+LOW_W-1:0]         tag_wr_data,
    input  logic                          tag_almost_full,
    output logic [OUT_W-1:0]              outstanding
);

    state_t                  state_q;
    state_t                  state_d;
    logic [ID_W-1:0]         last_grant_q;
    logic [NUM_REQ-1:0]      arb_grant;
    logic [ID_W-1:0]         arb_idx;
    logic                    arb_vld;
    logic                    can_issue;
    logic                    load;
    logic                    ar_hs;
    logic                    r_done;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [7:0]              sel_len;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic [7:0]              arlen_q;
    logic [ID_W-1:0]         arid_q;
    logic [OUT_W-1:0]        out_q;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .grant_vld  (arb_vld)
    );

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_addr |= {ADDR_WIDTH{arb_grant[i]}}
                      & req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_len  |= {8{arb_grant[i]}} & req_len[i*8 +: 8];
        end
    end

    assign can_issue = arb_vld & ~tag_almost_full
                     & (out_q < OUT_W'(MAX_OUTSTANDING));
    // Reset wins over a coincident handshake so no tag is pushed.
    assign ar_hs  = m_arvalid & m_arready & ~rst;
    assign r_done = m_rvalid & m_rready & m_rlast;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (can_issue) begin
                    state_d = ISSUE;
                    load    = 1'b1;
                end
            end
            ISSUE: begin
                if (m_arready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arid_q       <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            out_q        <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                araddr_q <= sel_addr;
                arlen_q  <= sel_len;
                arid_q   <= arb_idx;
            end
            if (ar_hs) begin
                last_grant_q <= arid_q;
            end
            if (ar_hs && !r_done && out_q != OUT_W'(MAX_OUTSTANDING)) begin
                out_q <= out_q + OUT_W'(1);
            end else if (r_done && !ar_hs && out_q != '0) begin
                out_q <= out_q - OUT_W'(1);
            end
        end
    end

    assign m_arvalid   = (state_q == ISSUE);
    assign m_araddr    = araddr_q;
    assign m_arlen     = arlen_q;
    assign m_arid      = arid_q;
    assign req_ready   = ar_hs ? (NUM_REQ'(1) << arid_q) : '0;
    assign tag_wr_en   = ar_hs;
    assign tag_wr_data = {arid_q, araddr_q[LOW_W-1:0]};
    assign outstanding = out_q;

endmodule

// File: tb/tb_axi_rd_sched.sv
// Scoreboard bench for axi_rd_sched (default parameters).
// Prio scenario runs only when AXI_RD_SCHED_PRIO0_EN is defined.
module tb_axi_rd_sched;

    localparam int NR = 4;
    localparam int AW = 28;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*8-1:0] req_len;
    logic [NR-1:0]   req_ready;
    logic [AW-1:0]   m_araddr;
    logic [7:0]      m_arlen;
    logic [1:0]      m_arid;
    logic            m_arvalid;
    logic            m_arready;
    logic            m_rvalid;
    logic            m_rready;
    logic            m_rlast;
    logic            tag_wr_en;
    logic [3:0]      tag_wr_data;
    logic            tag_almost_full;
    logic [3:0]      outstanding;

    axi_rd_sched dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_len         (req_len),
        .req_ready       (req_ready),
        .m_araddr        (m_araddr),
        .m_arlen         (m_arlen),
        .m_arid          (m_arid),
        .m_arvalid       (m_arvalid),
        .m_arready       (m_arready),
        .m_rvalid        (m_rvalid),
        .m_rready        (m_rready),
        .m_rlast         (m_rlast),
        .tag_wr_en       (tag_wr_en),
        .tag_wr_data     (tag_wr_data),
        .tag_almost_full (tag_almost_full),
        .outstanding     (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_hs = -10;
    int   tag_cnt = 0;
    int   drv_seq[NR] = '{default: 0};
    int   exp_seq[NR] = '{default: 0};
    int   remain[NR] = '{default: 0};

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] gen_addr(input int i, input int n);
        return AW'(i * 1048576 + n * 16 + ((i + n) % 4));
    endfunction

    function automatic logic [7:0] gen_len(input int i, input int n);
        return 8'(i * 16 + n);
    endfunction

    task automatic set_req(input int i);
        req_addr[i*AW +: AW] = gen_addr(i, drv_seq[i]);
        req_len[i*8 +: 8]    = gen_len(i, drv_seq[i]);
    endtask

    task automatic load(input int i, input int n);
        set_req(i);
        remain[i]    = n - 1;
        req_valid[i] = 1'b1;
    endtask

    task automatic push_exp(input int i);
        exp_t e;
        e.id   = 2'(i);
        e.addr = gen_addr(i, exp_seq[i]);
        e.len  = gen_len(i, exp_seq[i]);
        exp_seq[i]++;
        exp_q.push_back(e);
    endtask

    task automatic mon_hs();
        exp_t       e;
        int         w;
        logic [3:0] oh;
        if (exp_q.size() == 0) begin
            chk("unexpected_ar", 64'(exp_q.size()), 1);
            return;
        end
        e  = exp_q.pop_front();
        oh = 4'b0001 << e.id;
        chk("ar_id", m_arid, e.id);
        chk("ar_addr", m_araddr, e.addr);
        chk("ar_len", m_arlen, e.len);
        chk("req_ready", req_ready, oh);
        chk("tag_data", tag_wr_data, {e.id, e.addr[1:0]});
        chk("hs_gap", 64'((cyc - last_hs) >= 2), 1);
        last_hs = cyc;
        w = int'(e.id);
        drv_seq[w]++;
        if (remain[w] > 0) begin
            remain[w]--;
            set_req(w);
        end else begin
            req_valid[w] = 1'b0;
        end
    endtask

    // Sample just ahead of the rising edge, then return on the falling edge.
    task automatic tick();
        #3;
        if (tag_wr_en === 1'b1) tag_cnt++;
        if (m_arvalid === 1'b1 && m_arready === 1'b1 && rst === 1'b0)
            mon_hs();
        else if (tag_wr_en === 1'b1 || (|req_ready) === 1'b1)
            chk("spurious", {tag_wr_en, req_ready}, 0);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_drain(input string tag, input int max);
        for (int k = 0; k < max; k++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk(tag, 64'(exp_q.size()), 0);
    endtask

    task automatic wait_arvalid(input string tag, input int max);
        for (int k = 0; k < max; k++) begin
            if (m_arvalid === 1'b1) break;
            tick();
        end
        chk(tag, m_arvalid, 1);
    endtask

    task automatic rlast(input int n);
        m_rvalid = 1'b1;
        m_rready = 1'b1;
        m_rlast  = 1'b1;
        repeat (n) tick();
        m_rvalid = 1'b0;
        m_rready = 1'b0;
        m_rlast  = 1'b0;
    endtask

    initial begin
        int tc0;
        rst             = 1'b1;
        req_valid       = '0;
        req_addr        = '0;
        req_len         = '0;
        m_arready       = 1'b0;
        m_rvalid        = 1'b0;
        m_rready        = 1'b0;
        m_rlast         = 1'b0;
        tag_almost_full = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        chk("rst_arvalid", m_arvalid, 0);
        chk("rst_araddr", m_araddr, 0);
        chk("rst_arlen", m_arlen, 0);
        chk("rst_arid", m_arid, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_tag_en", tag_wr_en, 0);
        chk("rst_tag_data", tag_wr_data, 0);
        chk("rst_out", outstanding, 0);
        rst = 1'b0;
        tick();

        // Round-robin order from reset with every requester valid
        m_arready = 1'b1;
        load(0, 2);
        load(1, 1);
        load(2, 1);
        load(3, 1);
`ifdef AXI_RD_SCHED_PRIO0_EN
        push_exp(0); push_exp(0); push_exp(1); push_exp(2); push_exp(3);
`else
        push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
`endif
        chk("lat_pre", m_arvalid, 0);
        tick();
        chk("lat_post", m_arvalid, 1);
        wait_drain("rr_drain", 40);
        tick();
        chk("rr_out", outstanding, 5);
        rlast(5);
        chk("drain_out", outstanding, 0);
        rlast(1);
        chk("underflow", outstanding, 0);

        // AR backpressure
        m_arready = 1'b0;
        load(2, 1);
        push_exp(2);
        wait_arvalid("bp_wait", 10);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", m_arvalid, 1);
            chk("bp_addr", m_araddr, exp_q[0].addr);
            chk("bp_tag", tag_wr_en, 0);
            tick();
        end
        tc0 = tag_cnt;
        m_arready = 1'b1;
        wait_drain("bp_drain", 5);
        repeat (2) tick();
        chk("bp_push", 64'(tag_cnt - tc0), 1);
        rlast(1);

        // Outstanding limit
        load(1, 9);
        for (int k = 0; k < 8; k++) push_exp(1);
        wait_drain("lim_drain", 40);
        repeat (6) tick();
        chk("lim_out", outstanding, 8);
        chk("lim_block", m_arvalid, 0);
        push_exp(1);
        rlast(1);
        chk("lim_dec", outstanding, 7);
        chk("lim_idle", m_arvalid, 0);
        wait_drain("lim_drain2", 10);
        tick();
        chk("lim_out2", outstanding, 8);

        // Handshake coincident with burst completion
        rlast(5);
        chk("sim_pre", outstanding, 3);
        m_arready = 1'b0;
        load(3, 1);
        push_exp(3);
        wait_arvalid("sim_wait", 10);
        m_arready = 1'b1;
        m_rvalid  = 1'b1;
        m_rready  = 1'b1;
        m_rlast   = 1'b1;
        tick();
        m_rvalid = 1'b0;
        m_rready = 1'b0;
        m_rlast  = 1'b0;
        chk("sim_out", outstanding, 3);
        chk("sim_popped", 64'(exp_q.size()), 0);

        // Tag FIFO almost full blocks grants
        tag_almost_full = 1'b1;
        load(1, 1);
        push_exp(1);
        repeat (6) tick();
        chk("tag_block", m_arvalid, 0);
        chk("tag_pend", 64'(exp_q.size()), 1);
        tag_almost_full = 1'b0;
        wait_drain("tag_drain", 10);

        // Reset while an AR is pending
        m_arready = 1'b0;
        load(2, 1);
        wait_arvalid("rst_wait", 10);
        tc0       = tag_cnt;
        rst       = 1'b1;
        m_arready = 1'b1;
        req_valid = '0;
        tick();
        chk("rst_mid_valid", m_arvalid, 0);
        chk("rst_mid_out", outstanding, 0);
        chk("rst_mid_push", 64'(tag_cnt - tc0), 0);
        rst = 1'b0;
        tick();

        // last_grant restarts at requester 0
        load(2, 1);
        load(0, 1);
        push_exp(0);
        push_exp(2);
        wait_drain("lg_drain", 20);

`ifdef AXI_RD_SCHED_PRIO0_EN
        load(0, 3);
        load(1, 1);
        load(2, 1);
        load(3, 1);
        push_exp(0); push_exp(0); push_exp(0);
        push_exp(1); push_exp(2); push_exp(3);
        wait_drain("prio_drain", 40);
`endif

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
